rhs_spi_responder: RTL
======================

# rhs_spi_responder

Synthesizable RHS2116-style SPI responder: the device-side end of the link driven by `rhs_spi_master`. It oversamples SCLK/MOSI/CS on the system clock, decodes 32-bit command frames, maintains a small register file, and returns deterministic responses with the RHS two-frame pipeline latency. It serves as an in-FPGA stand-in for the headstage, for loopback and hardware-in-loop testing of the master and the acquisition path.

## Interface
- `NREGS`, 16: number of implemented read/write registers, at addresses 0..NREGS-1.
- `CHIP_ID`, 16'h0020: value returned by a read of address 8'hFF.
- `clk` in 1: system clock, at least 8× the SCLK frequency.
- `rstn` in 1: reset; one clock; reset is asynchronous and active-low.
- `SCLK` in 1: SPI clock, CPOL=0/CPHA=0, asynchronous to `clk`.
- `MOSI` in 1: command data, MSB first.
- `CS` in 1: frame select, active low.
- `MISO` out 1: response data, MSB first; 0 while CS is high.
- `cmd_valid` out 1: one-clk pulse when a valid frame commits.
- `cmd_word` out 32: the last committed command word.
- `frame_error` out 1: one-clk pulse when a frame is discarded.

## Operation
- SCLK, MOSI and CS pass through 2-flop synchronizers. Edges are detected on the synchronized SCLK and CS.
- States:
  - IDLE → SHIFT on a CS falling edge. `tx_shift` loads `q1`, `bit_cnt` clears, and MISO drives `tx_shift[31]`.
  - In SHIFT:
    - SCLK rising: `rx_shift <= {rx_shift[30:0], MOSI}`, and `bit_cnt` increments, saturating at 33.
    - SCLK falling: `tx_shift` shifts left; MISO drives the new bit 31.
  - SHIFT → COMMIT on a CS rising edge with `bit_cnt == 32`.
  - SHIFT → IDLE on a CS rising edge with any other count. `frame_error` pulses; there is no commit and the pipeline does not move.
  - COMMIT (1 clk): decode `rx_shift`, execute it, then `q1 <= q0`, `q0 <= resp`, `cmd_word <= rx_shift`, pulse `cmd_valid`, → IDLE.
- Decode on bits [31:30]:
  - 2'b00 CONVERT, channel `ch = [21:16]`: `resp = {16'h8000 | {10'h0, ch}, {ch, 10'h000}}`.
  - 2'b01 CLEAR: `resp = 32'h0000_0000`.
  - 2'b10 WRITE, `addr = [23:16]`, `data = [15:0]`:
    - If `addr < NREGS`, `reg[addr] <= data`; otherwise the write is ignored.
    - `resp = {16'hFFFF, data}` in both cases.
  - 2'b11 READ, `addr = [23:16]`:
    - `resp = {16'h0000, reg[addr]}` for implemented addresses.
    - `resp = {16'h0000, CHIP_ID}` for addr 8'hFF.
    - `resp = 32'h0` for any other address.
  - A read uses the register value after any write in earlier frames.
- Pipeline latency: the response to the frame-n command is shifted out during frame n+2. The first two frames after reset return 32'h0.

## Timing
- Reset values: MISO=0, `cmd_valid`=0, `frame_error`=0, `cmd_word`=0. In addition, `q0`, `q1`, `tx_shift`, `rx_shift`, `bit_cnt` and all registers are 0, and the state is IDLE.
- CS fall (pin) → MISO = bit 31: 3 clk (2 sync + 1 register).
- SCLK fall (pin) → next MISO bit: 3 clk.
- SCLK high time and low time must each be at least 4 clk.
- CS rise (pin) → `cmd_valid` or `frame_error` pulse: 4 clk.
- A new CS fall must not occur until at least 2 clk after the pulse. `q1` is stable by then.
- SCLK edges while CS is high: ignored.
- MISO is forced to 0 within 3 clk of CS rising.
- Reset mid-frame: the frame is aborted immediately with no pulse, and the pipeline is cleared.
- Simultaneous synced CS rise and SCLK edge: the CS rise wins; the SCLK edge is ignored.

## Test plan
- Two frames of WRITE 32'h8005_1234, then READ 32'hC005_0000, then READ 32'hC005_0000, then CONVERT:
  - Frame 3 MISO = 32'hFFFF_1234 (response to the first write).
  - Frame 4 MISO = 32'hFFFF_1234 (response to the second write).
  - Frame 5 MISO = 32'h0000_1234 (response to the first read).
  - Frames 1-2 MISO = 0.
- CONVERT ch 31 (32'h001F_0000), then two CLEARs:
  - Third-frame MISO = 32'h801F_7C00.
  - `cmd_word` = 32'h001F_0000 after the first commit.
- Master sending 32'hDEADBEEF (READ of addr 0xAD, unimplemented) → response two frames later = 32'h0. `cmd_valid` pulses each frame.
- READ 32'hC0FF_0000 → response = 32'h0000_0020.
- Short frame of 20 SCLKs → `frame_error` pulse, no `cmd_valid`, and the next frame's MISO is unchanged from the previously queued `q1`.
- `rstn` low after 10 SCLKs of a WRITE 32'h8003_00AA → MISO=0 and all outputs at reset values. A READ of addr 3 two frames later returns 32'h0.

Source files
------------

// File: rtl/rhs_spi_responder_if.sv
// rtl/rhs_spi_responder_if.sv - SPI pins and command-status bundle for the RHS responder
interface rhs_spi_responder_if;
  logic        SCLK;
  logic        MOSI;
  logic        CS;
  logic        MISO;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        frame_error;

  modport master (output SCLK, MOSI, CS, input MISO, cmd_valid, cmd_word, frame_error);
  modport slave  (input SCLK, MOSI, CS, output MISO, cmd_valid, cmd_word, frame_error);
endinterface

// File: rtl/rhs_spi_responder.sv
// rtl/rhs_spi_responder.sv - oversampled RHS2116-style SPI responder with two-frame response pipeline
module rhs_spi_responder #(
  parameter int          NREGS   = 16,
  parameter logic [15:0] CHIP_ID = 16'h0020
) (
  input  logic               clk,
  input  logic               rstn,
  rhs_spi_responder_if.slave spi
);
  localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [8:0] NREGS_W = 9'(NREGS);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state, state_n;
  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic [31:0] rx_shift, tx_shift, q0, q1, resp, cmd_word;
  logic [5:0]  bit_cnt;
  logic        miso, cmd_valid, err_pend, frame_error, wr_en;
  logic [15:0] regs [NREGS];
  logic [7:0]  addr;
  logic [5:0]  ch;
  logic [15:0] data;

  wire sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  wire sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  wire cs_rise   = cs_sync[1] & ~cs_sync[2];
  wire cs_fall   = ~cs_sync[1] & cs_sync[2];

  assign spi.MISO        = miso;
  assign spi.cmd_valid   = cmd_valid;
  assign spi.cmd_word    = cmd_word;
  assign spi.frame_error = frame_error;

  // CS synchronizer idles high so reset release never looks like a frame start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync <= '0;
      cs_sync   <= 3'b111;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi.SCLK};
      cs_sync   <= {cs_sync[1:0], spi.CS};
      mosi_sync <= {mosi_sync[0], spi.MOSI};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    resp    = '0;
    wr_en   = 1'b0;
    addr    = rx_shift[23:16];
    ch      = rx_shift[21:16];
    data    = rx_shift[15:0];
    case (state)
      IDLE:    if (cs_fall) state_n = SHIFT;
      SHIFT:   if (cs_rise) state_n = (bit_cnt == 6'd32) ? COMMIT : IDLE;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    case (rx_shift[31:30])
      2'b00: resp = {16'h8000 | {10'h000, ch}, ch, 10'h000};
      2'b01: resp = '0;
      2'b10: begin
        resp  = {16'hFFFF, data};
        wr_en = ({1'b0, addr} < NREGS_W);
      end
      default: begin
        if ({1'b0, addr} < NREGS_W) resp = {16'h0000, regs[addr[AW-1:0]]};
        else if (addr == 8'hFF)     resp = {16'h0000, CHIP_ID};
        else                        resp = '0;
      end
    endcase
  end

  // A CS rise takes priority over any SCLK edge seen in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_shift    <= '0;
      tx_shift    <= '0;
      q0          <= '0;
      q1          <= '0;
      bit_cnt     <= '0;
      miso        <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_word    <= '0;
      err_pend    <= 1'b0;
      frame_error <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      cmd_valid   <= 1'b0;
      err_pend    <= 1'b0;
      frame_error <= err_pend;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            tx_shift <= q1;
            bit_cnt  <= '0;
            miso     <= q1[31];
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            miso <= 1'b0;
            if (bit_cnt != 6'd32) err_pend <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[30:0], mosi_sync[1]};
              if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
            end
            if (sclk_fall) begin
              tx_shift <= {tx_shift[30:0], 1'b0};
              miso     <= tx_shift[30];
            end
          end
        end
        COMMIT: begin
          q1        <= q0;
          q0        <= resp;
          cmd_word  <= rx_shift;
          cmd_valid <= 1'b1;
          if (wr_en) regs[addr[AW-1:0]] <= data;
        end
        default: miso <= 1'b0;
      endcase
    end
  end
endmodule
